// File: rtl/or_nway_seq.sv
// Sequential N-way OR reducer: collects CHUNKS words of WIDTH bits over a
// valid/ready input stream and presents their bitwise OR plus an any-set flag.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// the result transfers on a rising edge where out_valid && out_ready. A
// producer may hold in_valid with stable data for any number of cycles and a
// consumer may stall out_ready indefinitely; nothing times out.
module or_nway_seq #(
    parameter int WIDTH  = 16,
    parameter int CHUNKS = 8,
    localparam int CW    = ($clog2(CHUNKS + 1) > 1) ? $clog2(CHUNKS + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_any,
    input  logic             out_ready,
    output logic             busy,
    output logic [CW-1:0]    count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    // Index of the final beat; accepting it completes the operation.
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // State, accumulator and beat counter registers; reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accumulate beats, hold the result, allow back-to-back restart.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // abort wins over a simultaneous beat, which is dropped.
                if (abort) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (in_valid) begin
                    acc_d = acc_q | in_data;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                // acc/cnt stay visible after hand-off until the next start.
                if (out_ready) begin
                    if (start) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode registered state only; no input-to-output path.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == RESULT);
        busy      = (state_q != IDLE);
        out_data  = acc_q;
        out_any   = |acc_q;
        count     = cnt_q;
        state     = state_q;
    end

endmodule
